// File: rtl/wam_pkg.sv
// -----------------------------------------------------------------------------
// wam_pkg
// Shared definitions for the Whac-A-Mole mole-lifecycle engine.
//   - default parameter values for the spawner and its LFSR
//   - popcount over a hole vector
//   - rotate-priority search for the first free hole from a start index
// Both helpers work on 32-bit vectors, the largest supported hole count.
// Callers zero-extend narrower hole vectors before passing them in.
// -----------------------------------------------------------------------------
package wam_pkg;

  localparam int         N_HOLES_DEF   = 8;
  localparam int         AGE_W_DEF     = 4;
  localparam int         LFSR_W_DEF    = 8;
  localparam logic [7:0] LFSR_TAPS_DEF = 8'h8E;
  localparam logic [7:0] SEED_DEF      = 8'hA5;
  localparam int         SCORE_W_DEF   = 16;
  localparam int         MAX_HOLES     = 32;

  // Result of the free-hole search: found=0 means every hole is occupied.
  typedef struct packed {
    logic       found;
    logic [4:0] idx;
  } pick_t;

  // Number of set bits in a (zero-extended) hole vector.
  function automatic logic [5:0] popcount(input logic [MAX_HOLES-1:0] v);
    logic [5:0] n;
    n = '0;
    for (int i = 0; i < MAX_HOLES; i++) begin
      n = n + 6'(v[i]);
    end
    return n;
  endfunction

  // First free hole scanning start, start+1, ... modulo n_holes.
  // n_holes must be a power of two so the wrap is a simple mask.
  // The scan runs from the far end backwards so the last hit written
  // is the one closest to start, which avoids an early-exit loop.
  function automatic pick_t find_free(input logic [MAX_HOLES-1:0] busy,
                                      input logic [4:0]           start,
                                      input int                   n_holes);
    pick_t      p;
    logic [4:0] mask;
    logic [4:0] j;
    p    = '0;
    mask = 5'(n_holes - 1);
    for (int k = MAX_HOLES - 1; k >= 0; k--) begin
      j = (start + 5'(k)) & mask;
      if ((k < n_holes) && !busy[j]) begin
        p.found = 1'b1;
        p.idx   = j;
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/wam_lfsr.sv
// -----------------------------------------------------------------------------
// wam_lfsr
// Right-shifting Galois LFSR used as the spawner's random source.
// Ports:
//   clk    in   system clock
//   clr_n  in   asynchronous active-low reset, loads SEED
//   adv    in   advance one step this cycle
//   num    out  current LFSR state (LFSR_W bits)
// An all-zero state is a lock-up state for this structure; if it is ever
// observed the register reloads SEED on the next edge, advancing or not.
// -----------------------------------------------------------------------------
module wam_lfsr
  import wam_pkg::*;
#(
  parameter int                LFSR_W    = LFSR_W_DEF,
  parameter logic [LFSR_W-1:0] LFSR_TAPS = LFSR_W'(LFSR_TAPS_DEF),
  parameter logic [LFSR_W-1:0] SEED      = LFSR_W'(SEED_DEF)
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic              adv,
  output logic [LFSR_W-1:0] num
);

  logic [LFSR_W-1:0] shifted;

  // Galois step: shift right and fold the tap mask in when a one falls out.
  always_comb begin
    shifted = num >> 1;
    if (num[0]) begin
      shifted = shifted ^ LFSR_TAPS;
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      num <= SEED;
    end else if (num == '0) begin
      num <= SEED;
    end else if (adv) begin
      num <= shifted;
    end
  end

endmodule

// File: rtl/wam_spawner.sv
// -----------------------------------------------------------------------------
// wam_spawner
// Mole-lifecycle engine: owns N_HOLES holes, spawns moles at pseudo-random
// free holes on game ticks, ages them out, and turns player hits into
// score/miss events with saturating counters.
// Ports:
//   clk        in   system clock
//   clr_n      in   asynchronous active-low reset
//   en         in   1 = run, 0 = freeze (state holds, pulses low)
//   tick       in   one-cycle game-step pulse
//   hit        in   per-hole debounced hit pulses
//   age_lim    in   mole lifetime in ticks (0 behaves as 1)
//   spawn_rto  in   spawn attempted when rnd < spawn_rto
//   max_live   in   cap on concurrent moles
//   holes      out  mole present per hole
//   hit_ok     out  pulse: hit landed on a live mole
//   hit_miss   out  pulse: hit landed on an empty hole
//   expired    out  pulse: mole aged out
//   score      out  saturating count of hit_ok events
//   misses     out  saturating count of hit_miss events
// All outputs are registered; inputs sampled at edge k appear after edge k.
// -----------------------------------------------------------------------------
module wam_spawner
  import wam_pkg::*;
#(
  parameter int                N_HOLES   = N_HOLES_DEF,
  parameter int                IDX_W     = $clog2(N_HOLES),
  parameter int                AGE_W     = AGE_W_DEF,
  parameter int                LFSR_W    = LFSR_W_DEF,
  parameter logic [LFSR_W-1:0] LFSR_TAPS = LFSR_W'(LFSR_TAPS_DEF),
  parameter logic [LFSR_W-1:0] SEED      = LFSR_W'(SEED_DEF),
  parameter int                SCORE_W   = SCORE_W_DEF
) (
  input  logic               clk,
  input  logic               clr_n,
  input  logic               en,
  input  logic               tick,
  input  logic [N_HOLES-1:0] hit,
  input  logic [AGE_W-1:0]   age_lim,
  input  logic [LFSR_W-1:0]  spawn_rto,
  input  logic [IDX_W:0]     max_live,
  output logic [N_HOLES-1:0] holes,
  output logic [N_HOLES-1:0] hit_ok,
  output logic [N_HOLES-1:0] hit_miss,
  output logic [N_HOLES-1:0] expired,
  output logic [SCORE_W-1:0] score,
  output logic [SCORE_W-1:0] misses
);

  localparam int                SUM_W = SCORE_W + 7;
  localparam logic [SUM_W-1:0]  SAT   = SUM_W'({SCORE_W{1'b1}});

  logic [LFSR_W-1:0]    rnd;
  logic                 adv;
  logic [AGE_W-1:0]     age     [N_HOLES];
  logic [AGE_W-1:0]     age_nxt [N_HOLES];
  logic [N_HOLES-1:0]   holes_nxt;
  logic [N_HOLES-1:0]   ok_nxt;
  logic [N_HOLES-1:0]   miss_nxt;
  logic [N_HOLES-1:0]   exp_nxt;
  logic [MAX_HOLES-1:0] holes_wide;
  logic [MAX_HOLES-1:0] ok_wide;
  logic [MAX_HOLES-1:0] miss_wide;
  logic [IDX_W:0]       live;
  logic [AGE_W-1:0]     lim;
  logic                 spawn_go;
  pick_t                pick;
  logic [SUM_W-1:0]     score_sum;
  logic [SUM_W-1:0]     miss_sum;
  logic [SCORE_W-1:0]   score_nxt;
  logic [SCORE_W-1:0]   misses_nxt;

  // The random source is sampled this cycle and steps on every accepted tick.
  assign adv = en & tick;

  wam_lfsr #(
    .LFSR_W    (LFSR_W),
    .LFSR_TAPS (LFSR_TAPS),
    .SEED      (SEED)
  ) u_lfsr (
    .clk   (clk),
    .clr_n (clr_n),
    .adv   (adv),
    .num   (rnd)
  );

  // Widen the per-hole vectors to the package helpers' fixed width.
  always_comb begin
    holes_wide                = '0;
    ok_wide                   = '0;
    miss_wide                 = '0;
    holes_wide[N_HOLES-1:0]   = holes;
    ok_wide[N_HOLES-1:0]      = ok_nxt;
    miss_wide[N_HOLES-1:0]    = miss_nxt;
  end

  // Spawn decision uses only registered state, so holes freed by a hit or
  // an expiry in this same cycle are never candidates.
  assign live     = (IDX_W + 1)'(popcount(holes_wide));
  assign lim      = (age_lim == '0) ? AGE_W'(1) : age_lim;
  assign pick     = find_free(holes_wide, 5'(rnd[IDX_W-1:0]), N_HOLES);
  assign spawn_go = tick && (rnd < spawn_rto) && (live < max_live) && pick.found;

  // Per-hole next state. A hit takes priority over aging, so a mole that is
  // hit on its expiry tick scores rather than expiring. A hit on the hole
  // being spawned is a miss (it was empty) and the spawn still lands.
  always_comb begin
    holes_nxt = holes;
    ok_nxt    = '0;
    miss_nxt  = '0;
    exp_nxt   = '0;
    for (int i = 0; i < N_HOLES; i++) begin
      age_nxt[i] = age[i];
      if (hit[i]) begin
        if (holes[i]) begin
          ok_nxt[i]    = 1'b1;
          holes_nxt[i] = 1'b0;
          age_nxt[i]   = '0;
        end else begin
          miss_nxt[i]  = 1'b1;
        end
      end else if (tick && holes[i]) begin
        if (age[i] >= lim) begin
          exp_nxt[i]   = 1'b1;
          holes_nxt[i] = 1'b0;
          age_nxt[i]   = '0;
        end else begin
          age_nxt[i]   = age[i] + AGE_W'(1);
        end
      end
      if (spawn_go && (pick.idx == 5'(i))) begin
        holes_nxt[i] = 1'b1;
        age_nxt[i]   = AGE_W'(1);
      end
    end
  end

  // Counters add the number of events this cycle and clamp at all-ones.
  always_comb begin
    score_sum  = SUM_W'(score)  + SUM_W'(popcount(ok_wide));
    miss_sum   = SUM_W'(misses) + SUM_W'(popcount(miss_wide));
    score_nxt  = (score_sum > SAT) ? '1 : score_sum[SCORE_W-1:0];
    misses_nxt = (miss_sum  > SAT) ? '1 : miss_sum[SCORE_W-1:0];
  end

  // Freeze holds every piece of state and forces the event pulses low.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      holes    <= '0;
      hit_ok   <= '0;
      hit_miss <= '0;
      expired  <= '0;
      score    <= '0;
      misses   <= '0;
      for (int i = 0; i < N_HOLES; i++) begin
        age[i] <= '0;
      end
    end else if (en) begin
      holes    <= holes_nxt;
      hit_ok   <= ok_nxt;
      hit_miss <= miss_nxt;
      expired  <= exp_nxt;
      score    <= score_nxt;
      misses   <= misses_nxt;
      for (int i = 0; i < N_HOLES; i++) begin
        age[i] <= age_nxt[i];
      end
    end else begin
      hit_ok   <= '0;
      hit_miss <= '0;
      expired  <= '0;
    end
  end

endmodule

// File: doc/wam_spawner.md
# wam_spawner

Parametrised mole-lifecycle engine for the Whac-A-Mole game: owns N holes, spawns moles at pseudo-random holes on game ticks, ages them out after a programmable lifetime, and resolves player hits into score/miss events. Successor to the fixed 8-hole generator. Adds:
- configurable hole count and counter widths
- random (not round-robin) hole selection with free-hole search
- a cap on concurrent moles
- a run/freeze enable
- hit/miss/expire event pulses and saturating score counters

Sits between the clock-divider/difficulty logic (tick, age_lim, spawn_rto, max_live) and the LED/display and scoring logic.

## Interface
- N_HOLES, 8: number of holes; power of two, 2..32
- IDX_W, $clog2(N_HOLES): hole index width
- AGE_W, 4: per-hole age counter width
- LFSR_W, 8: random generator width
- LFSR_TAPS, 8'h8E: Galois feedback mask (width LFSR_W)
- SEED, 8'hA5: LFSR reset/recovery value; must be nonzero
- SCORE_W, 16: score and miss counter width
- clk  in  1  system clock
- clr_n  in  1  asynchronous, active-low reset
- en  in  1  1 = run; 0 = freeze (no aging, no spawn, hits ignored)
- tick  in  1  one-cycle game-step pulse, already divided down
- hit  in  N_HOLES  per-hole debounced hit pulses
- age_lim  in  AGE_W  mole lifetime in ticks; 0 is treated as 1
- spawn_rto  in  LFSR_W  spawn threshold; spawn attempted when rnd < spawn_rto
- max_live  in  IDX_W+1  maximum concurrent moles
- holes  out  N_HOLES  mole present per hole
- hit_ok  out  N_HOLES  one-cycle pulse: hit on a live mole
- hit_miss  out  N_HOLES  one-cycle pulse: hit on an empty hole
- expired  out  N_HOLES  one-cycle pulse: mole aged out
- score  out  SCORE_W  saturating count of hit_ok events
- misses  out  SCORE_W  saturating count of hit_miss events

## Operation
- All outputs are registered. On reset: holes, all pulses, score, misses, and age counters are 0; LFSR = SEED.
- en=0: all state holds and pulse outputs are 0; tick and hit are ignored, not queued.
- **Hit** (every cycle, en=1):
  - hit[i] & holes[i]: clear hole i, zero age[i], pulse hit_ok[i], score+1.
  - hit[i] & ~holes[i]: pulse hit_miss[i], misses+1.
  - Several hits in the same cycle each count; the counter adds popcount, saturating at all-ones.
- **Tick aging** (tick=1, en=1), for each live hole not hit this cycle:
  - age[i] >= max(age_lim,1): clear hole, zero age, pulse expired[i].
  - otherwise age[i]+1.
- **Tick spawn** (tick=1, en=1), using registered holes and live = popcount(holes) at the start of the cycle:
  - Condition: rnd < spawn_rto and live < max_live.
  - Candidate c = rnd[IDX_W-1:0]. Pick the first free hole scanning c, c+1, ... modulo N_HOLES.
  - The chosen hole gets holes=1, age=1. No free hole: no spawn.
  - At most one spawn per tick.
  - Holes freed in this same cycle (hit or expire) are not eligible.
- The LFSR advances once per accepted tick, after being sampled. If it ever reads 0, it reloads SEED.
- Lifetime: a mole spawned at tick T is visible through ticks T+1 .. T+age_lim-1 and expires at tick T+age_lim.
- Simultaneous hit and expiry on the same hole: the hit wins (hit_ok, no expired).
- Hit on a hole being spawned this cycle: it is a miss (the hole was empty when sampled), and the spawn still happens.

## Timing
- Single-cycle latency: inputs sampled at edge k; holes, pulses, and counters are visible after edge k.
- Pulses last exactly one cycle.
- Mid-operation reset clears everything immediately (asynchronous). The first spawn after reset uses SEED.
- tick is assumed to be a single-cycle pulse. A held tick ages and spawns every cycle (legal, not filtered).

## Structure
- Shared package wam_pkg holds:
  - default constants (N_HOLES, AGE_W, LFSR_W, SEED, LFSR_TAPS)
  - a popcount function
  - a rotate-priority find-first-free function (N_HOLES-generic)
- Sub-module wam_lfsr (parameters LFSR_W, LFSR_TAPS, SEED; ports clk, clr_n, adv, num): Galois LFSR with zero-state recovery.
- Remaining logic: the per-hole age array, the spawn selector, and the counters.

## Test plan
- Reset → holes=0, score=0, misses=0, LFSR=SEED; with en=0, 10 ticks plus hit=8'hFF → no change, no pulses.
- spawn_rto=8'hFF, max_live=8, age_lim=3, one tick → exactly one hole set, at the index given by the LFSR low bits; three further ticks → the expired pulse fires on the 3rd, and the hole clears.
- Force rnd low bits to 5 with holes 5, 6 occupied → spawn lands in hole 7. With 5, 6, 7 occupied → spawn wraps to hole 0. With all 8 full → no spawn.
- max_live=2 with 2 moles live, spawn_rto=8'hFF → 20 ticks produce no third mole until one is hit.
- Same cycle: hit[3] on a live mole about to expire, plus tick → hit_ok[3]=1, expired[3]=0, score+1. hit=8'hF0 with holes=8'h30 → hit_ok=8'h30, hit_miss=8'hC0, score+2, misses+2.
- score preset near all-ones (SCORE_W=4, at 15) plus further hits → score saturates at 15.
